// File: rtl/irq_pkg.sv
// Shared types and constants for the interrupt sequencer.
// Imported by irq_sequencer and irq_prio_enc.
package irq_pkg;

  localparam int NUM_IRQ_DEF = 8;
  localparam int ID_W_DEF    = 3;
  localparam int CFG_AW      = 2;
  localparam int CFG_DW      = 8;

  localparam logic [CFG_AW-1:0] ADDR_MASK = 2'd0;
  localparam logic [CFG_AW-1:0] ADDR_PEND = 2'd1;
  localparam logic [CFG_AW-1:0] ADDR_ISR  = 2'd2;
  localparam logic [CFG_AW-1:0] ADDR_CTRL = 2'd3;

  localparam int CTRL_GEN_BIT = 0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Find-first-set encoder: lowest set index wins, since index 0 is the
// highest priority. valid=0 when no bit is set (idx is then 0).
module irq_prio_enc
  import irq_pkg::*;
#(
  parameter int W  = NUM_IRQ_DEF,
  parameter int IW = ID_W_DEF
) (
  input  logic [W-1:0]  vec,
  output logic          valid,
  output logic [IW-1:0] idx
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        valid = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// Sequential interrupt controller: edge-latched requests, mask, global
// enable, nested in-service tracking and a held vector until acknowledge.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | no vector presented; waiting for an eligible candidate
// ST_REQ  | irq=1, int_num frozen until the core acknowledges
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ  = NUM_IRQ_DEF,
  parameter int                 ID_W     = ID_W_DEF,
  parameter logic [NUM_IRQ-1:0] MASK_RST = {NUM_IRQ{1'b1}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] intReq,
  // "int" is a reserved word, so the request to the core is named irq.
  output logic               irq,
  output logic [ID_W-1:0]    int_num,
  input  logic               int_ack,
  input  logic               eoi,
  input  logic               cfg_we,
  input  logic [CFG_AW-1:0]  cfg_addr,
  input  logic [CFG_DW-1:0]  cfg_wdata,
  output logic [CFG_DW-1:0]  cfg_rdata
);

  state_t             state;
  logic [NUM_IRQ-1:0] prev_req;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] isr;
  logic [NUM_IRQ-1:0] mask;
  logic               gen;

  logic [NUM_IRQ-1:0] req_edge;
  logic [NUM_IRQ-1:0] cand_vec;
  logic               cand_valid;
  logic [ID_W-1:0]    cand_idx;
  logic               isr_valid;
  logic [ID_W-1:0]    isr_top;
  logic               eligible;
  logic               ack_fire;
  logic [NUM_IRQ-1:0] ack_bit;
  logic [NUM_IRQ-1:0] eoi_bit;
  logic [NUM_IRQ-1:0] w1c_bit;
  logic [NUM_IRQ-1:0] pend_nxt;
  logic [NUM_IRQ-1:0] isr_nxt;
  logic               wr_mask;
  logic               wr_ctrl;

  assign req_edge = intReq & ~prev_req;
  assign cand_vec = pend & ~mask;

  irq_prio_enc #(.W(NUM_IRQ), .IW(ID_W)) u_cand_enc (
    .vec   (cand_vec),
    .valid (cand_valid),
    .idx   (cand_idx)
  );

  irq_prio_enc #(.W(NUM_IRQ), .IW(ID_W)) u_isr_enc (
    .vec   (isr),
    .valid (isr_valid),
    .idx   (isr_top)
  );

  // Only a strictly higher priority than the current in-service level may nest.
  assign eligible = gen && cand_valid && (!isr_valid || (cand_idx < isr_top));
  assign ack_fire = (state == ST_REQ) && int_ack;

  assign wr_mask = cfg_we && (cfg_addr == ADDR_MASK);
  assign wr_ctrl = cfg_we && (cfg_addr == ADDR_CTRL);

  always_comb begin
    ack_bit = '0;
    eoi_bit = '0;
    w1c_bit = '0;
    if (ack_fire)
      ack_bit[int_num] = 1'b1;
    if (eoi && isr_valid)
      eoi_bit[isr_top] = 1'b1;
    if (cfg_we && (cfg_addr == ADDR_PEND))
      w1c_bit = cfg_wdata[NUM_IRQ-1:0];
  end

  // A new edge wins over same-cycle clears; eoi retires the old top before
  // the acknowledged bit is added.
  assign pend_nxt = (pend & ~w1c_bit & ~ack_bit) | req_edge;
  assign isr_nxt  = (isr & ~eoi_bit) | ack_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_req <= '0;
      pend     <= '0;
      isr      <= '0;
      mask     <= MASK_RST;
      gen      <= 1'b0;
    end else begin
      prev_req <= intReq;
      pend     <= pend_nxt;
      isr      <= isr_nxt;
      if (wr_mask)
        mask <= cfg_wdata[NUM_IRQ-1:0];
      if (wr_ctrl)
        gen <= cfg_wdata[CTRL_GEN_BIT];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      irq     <= 1'b0;
      int_num <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (eligible) begin
            state   <= ST_REQ;
            irq     <= 1'b1;
            int_num <= cand_idx;
          end
        end
        ST_REQ: begin
          if (int_ack) begin
            state <= ST_IDLE;
            irq   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_MASK: cfg_rdata = CFG_DW'(mask);
      ADDR_PEND: cfg_rdata = CFG_DW'(pend);
      ADDR_ISR:  cfg_rdata = CFG_DW'(isr);
      ADDR_CTRL: cfg_rdata[CTRL_GEN_BIT] = gen;
      default:   cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: a vector table for the main flows plus
// hand-written sequences for reset mid-handshake and edge/ack collisions.
module tb_irq_sequencer;
  import irq_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] intReq = '0;
  logic       irq;
  logic [2:0] int_num;
  logic       int_ack = 1'b0;
  logic       eoi = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;

  int tests = 0;
  int fails = 0;

  irq_sequencer #(.NUM_IRQ(8), .ID_W(3), .MASK_RST(8'hFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .intReq    (intReq),
    .irq       (irq),
    .int_num   (int_num),
    .int_ack   (int_ack),
    .eoi       (eoi),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] req;
    logic       ack;
    logic       eoi;
    logic       e_int;
    logic [2:0] e_num;
    logic [7:0] e_pend;
    logic [7:0] e_isr;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic we, logic [1:0] addr, logic [7:0] wdata,
                              logic [7:0] req, logic ack, logic e,
                              logic e_int, logic [2:0] e_num,
                              logic [7:0] e_pend, logic [7:0] e_isr);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.req = req;
    v.ack = ack; v.eoi = e; v.e_int = e_int; v.e_num = e_num;
    v.e_pend = e_pend; v.e_isr = e_isr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [7:0] d);
    cfg_addr = a;
    #1;
    d = cfg_rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cfg_we = 1'b0; int_ack = 1'b0; eoi = 1'b0;
  endtask

  logic [7:0] rd;

  initial begin
    // Reset state
    #12;
    chk("rst irq", {7'd0, irq}, 8'h00);
    chk("rst num", {5'd0, int_num}, 8'h00);
    read_reg(ADDR_PEND, rd); chk("rst pend", rd, 8'h00);
    read_reg(ADDR_ISR,  rd); chk("rst isr",  rd, 8'h00);
    read_reg(ADDR_MASK, rd); chk("rst mask", rd, 8'hFF);
    read_reg(ADDR_CTRL, rd); chk("rst ctrl", rd, 8'h00);
    rst = 1'b1;

    //             we   addr       wdata  req    ack eoi int num pend   isr
    vq.push_back(mk(1, ADDR_MASK, 8'h00, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00)); // 0
    vq.push_back(mk(1, ADDR_CTRL, 8'h01, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h20, 0, 0,  0, 0, 8'h20, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 5, 8'h20, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h00, 8'h20));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 1,  0, 0, 8'h00, 8'h00)); // 5
    vq.push_back(mk(0, 0,         8'h00, 8'h44, 0, 0,  0, 0, 8'h44, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 2, 8'h44, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h40, 8'h04));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  0, 0, 8'h40, 8'h04));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 1,  0, 0, 8'h40, 8'h00)); // 10
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 6, 8'h40, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h00, 8'h40));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 1,  0, 0, 8'h00, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h10, 0, 0,  0, 0, 8'h10, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 4, 8'h10, 8'h00)); // 15
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h00, 8'h10));
    vq.push_back(mk(0, 0,         8'h00, 8'h40, 0, 0,  0, 0, 8'h40, 8'h10));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  0, 0, 8'h40, 8'h10));
    vq.push_back(mk(0, 0,         8'h00, 8'h02, 0, 0,  0, 0, 8'h42, 8'h10));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 1, 8'h42, 8'h10)); // 20
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h40, 8'h12));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 1,  0, 0, 8'h40, 8'h10));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 1,  0, 0, 8'h40, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 6, 8'h40, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h00, 8'h40)); // 25
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 1,  0, 0, 8'h00, 8'h00));
    vq.push_back(mk(1, ADDR_MASK, 8'hFF, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h08, 0, 0,  0, 0, 8'h08, 8'h00));
    vq.push_back(mk(1, ADDR_MASK, 8'hF7, 8'h00, 0, 0,  0, 0, 8'h08, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 3, 8'h08, 8'h00)); // 30
    vq.push_back(mk(1, ADDR_PEND, 8'h08, 8'h08, 0, 0,  1, 3, 8'h08, 8'h00));
    vq.push_back(mk(1, ADDR_MASK, 8'hFF, 8'h00, 0, 0,  1, 3, 8'h08, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h00, 8'h08));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 1,  0, 0, 8'h00, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 1,  0, 0, 8'h00, 8'h00)); // 35
    vq.push_back(mk(1, ADDR_MASK, 8'h00, 8'h00, 0, 0,  0, 0, 8'h00, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h10, 0, 0,  0, 0, 8'h10, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 4, 8'h10, 8'h00));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 0,  0, 0, 8'h00, 8'h10));
    vq.push_back(mk(0, 0,         8'h00, 8'h02, 0, 0,  0, 0, 8'h02, 8'h10)); // 40
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 0,  1, 1, 8'h02, 8'h10));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 1, 1,  0, 0, 8'h00, 8'h02));
    vq.push_back(mk(0, 0,         8'h00, 8'h00, 0, 1,  0, 0, 8'h00, 8'h00));

    @(negedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      cfg_we = vq[i].we; cfg_addr = vq[i].addr; cfg_wdata = vq[i].wdata;
      intReq = vq[i].req; int_ack = vq[i].ack; eoi = vq[i].eoi;
      step();
      chk($sformatf("v%0d irq", i), {7'd0, irq}, {7'd0, vq[i].e_int});
      if (vq[i].e_int)
        chk($sformatf("v%0d num", i), {5'd0, int_num}, {5'd0, vq[i].e_num});
      read_reg(ADDR_PEND, rd); chk($sformatf("v%0d pend", i), rd, vq[i].e_pend);
      read_reg(ADDR_ISR,  rd); chk($sformatf("v%0d isr", i),  rd, vq[i].e_isr);
    end

    // New edge on the acknowledged source: ack clears, edge re-sets PEND.
    intReq = 8'h80; step();
    intReq = 8'h00; step();
    chk("col irq", {7'd0, irq}, 8'h01);
    chk("col num", {5'd0, int_num}, 8'h07);
    intReq = 8'h80; int_ack = 1'b1; step();
    chk("col ack irq", {7'd0, irq}, 8'h00);
    read_reg(ADDR_PEND, rd); chk("col pend", rd, 8'h80);
    read_reg(ADDR_ISR,  rd); chk("col isr",  rd, 8'h80);
    intReq = 8'h00; step();
    chk("col same lvl irq", {7'd0, irq}, 8'h00);
    eoi = 1'b1; step();
    step();
    chk("col after eoi irq", {7'd0, irq}, 8'h01);
    int_ack = 1'b1; step();
    eoi = 1'b1; step();

    // Asynchronous reset while a vector is presented.
    intReq = 8'h08; step();
    intReq = 8'h00; step();
    chk("pre-rst irq", {7'd0, irq}, 8'h01);
    chk("pre-rst num", {5'd0, int_num}, 8'h03);
    #1 rst = 1'b0;
    #1;
    chk("arst irq", {7'd0, irq}, 8'h00);
    chk("arst num", {5'd0, int_num}, 8'h00);
    read_reg(ADDR_PEND, rd); chk("arst pend", rd, 8'h00);
    read_reg(ADDR_ISR,  rd); chk("arst isr",  rd, 8'h00);
    read_reg(ADDR_MASK, rd); chk("arst mask", rd, 8'hFF);
    read_reg(ADDR_CTRL, rd); chk("arst ctrl", rd, 8'h00);
    step();
    @(negedge clk) rst = 1'b1;
    cfg_we = 1'b1; cfg_addr = ADDR_MASK; cfg_wdata = 8'h00; step();
    cfg_we = 1'b1; cfg_addr = ADDR_CTRL; cfg_wdata = 8'h01; step();
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post-rst quiet %0d", i), {7'd0, irq}, 8'h00);
    end
    intReq = 8'h04; step();
    intReq = 8'h00;
    begin
      int n = 0;
      while (!irq && n < 10) begin
        step();
        n++;
      end
    end
    chk("post-rst irq", {7'd0, irq}, 8'h01);
    chk("post-rst num", {5'd0, int_num}, 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
# irq_sequencer

Sequential interrupt controller between the external request lines and the RISCV core's `int`/`int_num` inputs, replacing the combinational priority encoder in the CPU top. It edge-detects and latches requests, applies a programmable mask and global enable, tracks in-service levels for nested priority, and holds a stable vector to the core until the core acknowledges it. Software configures it through a small register port.

## Interface
Parameters:
- NUM_IRQ, 8, number of request lines; index 0 is the highest priority.
- ID_W, 3, vector width, equal to clog2(NUM_IRQ).
- MASK_RST, 8'hFF, reset value of the mask register (all sources masked).

Ports:
- clk  in  1  system clock; all activity on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- intReq  in  NUM_IRQ  request lines; synchronous to clk; rising edge = request.
- int  out  1  interrupt request to the core.
- int_num  out  ID_W  vector of the request; valid while int=1.
- int_ack  in  1  one-cycle acknowledge from the core.
- eoi  in  1  one-cycle end-of-interrupt; retires the highest-priority in-service bit.
- cfg_we  in  1  register write strobe.
- cfg_addr  in  2  register select.
- cfg_wdata  in  8  write data.
- cfg_rdata  out  8  read data; combinational from cfg_addr.

## Operation
- Registers:
  - 0 MASK: read/write; 1 = masked.
  - 1 PEND: read; writing 1 clears the bit.
  - 2 ISR: in-service; read-only.
  - 3 CTRL: bit0 = global enable (GEN); other bits read 0.
- Edge detection: prev_req register. Set PEND[i] when intReq[i]=1 and prev_req[i]=0.
- Candidate: highest-priority set bit of PEND & ~MASK, qualified by GEN=1. It is eligible only if its index is strictly lower than the highest-priority ISR bit, or ISR=0.
- FSM states: IDLE and REQ.
  - IDLE -> REQ when an eligible candidate exists. On entry, latch the candidate into int_num; int=1.
  - REQ -> IDLE on int_ack=1. On that edge, clear PEND[int_num] and set ISR[int_num]; int=0 from the next cycle.
  - In REQ, int_num is frozen. A higher-priority arrival waits for the next IDLE pass. Masking, clearing or disabling the latched source does not withdraw it; the ack still services it.
- eoi: clears the highest-priority set ISR bit. Ignored when ISR=0.
- Simultaneous events:
  - New edge on i in the same cycle as an ack of i or a W1C of PEND[i]: PEND[i] ends set.
  - eoi and int_ack in the same cycle: eoi applies to the old ISR, then the ack's bit is set.
  - int_ack while in IDLE: ignored.
- Reset (asynchronous, any time, including mid-handshake):
  - State returns to IDLE, with int=0 and int_num=0.
  - PEND=0, ISR=0, MASK=MASK_RST, GEN=0, prev_req=0.
  - Any request lost by reset is not re-raised.

## Timing
- intReq[i] rises before edge t: PEND[i] is set at edge t. If eligible, REQ is entered at edge t+1, so int=1 after t+1. Minimum latency is 2 clocks.
- int_ack sampled at edge a: int=0 after edge a. The next vector can assert at edge a+1 at the earliest.
- eoi sampled at edge e: a newly eligible lower-priority source can assert int after edge e+1.
- cfg writes take effect on the write edge. Eligibility uses the updated value from the next cycle.
- cfg_rdata shows PEND/ISR as registered, with no bypass of same-cycle updates.

## Structure
- Package irq_pkg holds:
  - state encoding (IDLE, REQ);
  - register address constants (MASK, PEND, ISR, CTRL);
  - NUM_IRQ/ID_W defaults;
  - CTRL bit position of GEN.
- Sub-module irq_prio_enc: parameterized find-first-set (lowest index) returning a valid flag plus index. It is instantiated twice, once for the candidate and once for the ISR top level.

## Test plan
- Reset, then GEN=1 and MASK=0x00; pulse intReq[5] -> PEND=0x20, int=1 with int_num=5 two clocks after; int_ack -> int=0, PEND=0x00, ISR=0x20.
- Raise intReq[6] and intReq[2] in the same cycle -> int_num=2 first; ack then eoi -> int_num=6 follows.
- Nesting: ISR=0x10 (4 in service); pulse 6 -> no int; pulse 1 -> int_num=1; ack -> ISR=0x12; eoi -> ISR=0x10.
- MASK=0xFF, pulse intReq[3] -> PEND=0x08, int stays 0; write MASK=0xF7 -> int_num=3 asserts; W1C to PEND with a new edge on 3 in the same cycle -> PEND[3] remains 1.
- Assert rst=0 while int=1 and before ack -> int=0, int_num=0, PEND=ISR=0, MASK=0xFF, GEN=0 immediately; after release, no interrupt until a new edge arrives.
- eoi with ISR=0, and int_ack in IDLE -> no state change.
